// File: rtl/ftc_skid_stage.sv
// Two-entry skid stage for the FTC token path: a head register drives the outputs and a
// skid register absorbs one extra token. Define FTC_SKID_TOKCNT_EN to build the delivery counter.
module ftc_skid_stage #(
    parameter int NODE_W = 16,
    parameter int GEN_W  = 12,
    parameter int OPR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NODE_W-1:0] node_i,
    input  logic [GEN_W-1:0]  gen_i,
    input  logic [OPR_W-1:0]  opr0_i,
    input  logic [OPR_W-1:0]  opr1_i,
    input  logic [1:0]        mem_wen_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NODE_W-1:0] node_o,
    output logic [GEN_W-1:0]  gen_o,
    output logic [OPR_W-1:0]  opr0_o,
    output logic [OPR_W-1:0]  opr1_o,
    output logic [1:0]        mem_wen_o,
    output logic              w_en_cex_o,
    output logic [1:0]        occ_o,
    output logic [15:0]       tok_cnt_o
);

    // State encoding doubles as the occupancy count.
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;
    localparam logic [1:0] MW_INS  = 2'b10;

    logic [1:0]        r_state;
    logic              r_in_rdy;

    logic [NODE_W-1:0] r_hd_node;
    logic [GEN_W-1:0]  r_hd_gen;
    logic [OPR_W-1:0]  r_hd_opr0;
    logic [OPR_W-1:0]  r_hd_opr1;
    logic [1:0]        r_hd_mw;

    logic [NODE_W-1:0] r_sk_node;
    logic [GEN_W-1:0]  r_sk_gen;
    logic [OPR_W-1:0]  r_sk_opr0;
    logic [OPR_W-1:0]  r_sk_opr1;
    logic [1:0]        r_sk_mw;

    logic              w_out_vld;
    logic              w_acc;
    logic              w_del;
    logic [1:0]        w_nxt_state;
    logic              w_ld_hd_in;
    logic              w_ld_hd_sk;
    logic              w_ld_sk;

    assign w_out_vld = (r_state != S_EMPTY);
    assign w_acc     = in_valid & r_in_rdy;
    assign w_del     = w_out_vld & out_ready;

    always_comb begin
        w_nxt_state = r_state;
        w_ld_hd_in  = 1'b0;
        w_ld_hd_sk  = 1'b0;
        w_ld_sk     = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_acc) begin
                    w_nxt_state = S_ONE;
                    w_ld_hd_in  = 1'b1;
                end
            end
            S_ONE: begin
                case ({w_acc, w_del})
                    2'b10: begin
                        w_nxt_state = S_FULL;
                        w_ld_sk     = 1'b1;
                    end
                    2'b01: w_nxt_state = S_EMPTY;
                    2'b11: w_ld_hd_in = 1'b1;
                    default: w_nxt_state = S_ONE;
                endcase
            end
            S_FULL: begin
                // in_ready is low here, so only a delivery can happen.
                if (w_del) begin
                    w_nxt_state = S_ONE;
                    w_ld_hd_sk  = 1'b1;
                end
            end
            default: w_nxt_state = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_EMPTY;
            r_in_rdy <= 1'b0;
        end else begin
            r_state  <= w_nxt_state;
            r_in_rdy <= (w_nxt_state != S_FULL);
        end
    end

    // Head fields are cleared in reset so the outputs read zero while rst is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hd_node <= '0;
            r_hd_gen  <= '0;
            r_hd_opr0 <= '0;
            r_hd_opr1 <= '0;
            r_hd_mw   <= '0;
        end else if (w_ld_hd_in) begin
            r_hd_node <= node_i;
            r_hd_gen  <= gen_i;
            r_hd_opr0 <= opr0_i;
            r_hd_opr1 <= opr1_i;
            r_hd_mw   <= mem_wen_i;
        end else if (w_ld_hd_sk) begin
            r_hd_node <= r_sk_node;
            r_hd_gen  <= r_sk_gen;
            r_hd_opr0 <= r_sk_opr0;
            r_hd_opr1 <= r_sk_opr1;
            r_hd_mw   <= r_sk_mw;
        end
    end

    always_ff @(posedge clk) begin
        if (w_ld_sk) begin
            r_sk_node <= node_i;
            r_sk_gen  <= gen_i;
            r_sk_opr0 <= opr0_i;
            r_sk_opr1 <= opr1_i;
            r_sk_mw   <= mem_wen_i;
        end
    end

`ifdef FTC_SKID_TOKCNT_EN
    logic [15:0] r_tok_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tok_cnt <= '0;
        end else if (w_del) begin
            r_tok_cnt <= r_tok_cnt + 16'd1;
        end
    end

    assign tok_cnt_o = r_tok_cnt;
`else
    assign tok_cnt_o = '0;
`endif

    assign in_ready   = r_in_rdy;
    assign out_valid  = w_out_vld;
    assign occ_o      = r_state;
    assign node_o     = r_hd_node;
    assign gen_o      = r_hd_gen;
    assign opr0_o     = r_hd_opr0;
    assign opr1_o     = r_hd_opr1;
    assign mem_wen_o  = r_hd_mw;
    assign w_en_cex_o = ~(w_out_vld && (r_hd_mw == MW_INS));

endmodule

// File: tb/tb_ftc_skid_stage.sv
// Directed bench for ftc_skid_stage: vector table plus hand sequences for full, reset and
// counter-wrap cases. Counter expectations follow FTC_SKID_TOKCNT_EN.
module tb_ftc_skid_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] node_i = '0;
    logic [11:0] gen_i = '0;
    logic [31:0] opr0_i = '0;
    logic [31:0] opr1_i = '0;
    logic [1:0]  mem_wen_i = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] node_o;
    logic [11:0] gen_o;
    logic [31:0] opr0_o;
    logic [31:0] opr1_o;
    logic [1:0]  mem_wen_o;
    logic        w_en_cex_o;
    logic [1:0]  occ_o;
    logic [15:0] tok_cnt_o;

    int          n_tests = 0;
    int          n_fail = 0;
    logic        prev_ov = 1'b0;
    logic [15:0] exp_cnt = '0;

    always #5 clk = ~clk;

    ftc_skid_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .node_i(node_i), .gen_i(gen_i), .opr0_i(opr0_i), .opr1_i(opr1_i), .mem_wen_i(mem_wen_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .node_o(node_o), .gen_o(gen_o), .opr0_o(opr0_o), .opr1_o(opr1_o), .mem_wen_o(mem_wen_o),
        .w_en_cex_o(w_en_cex_o), .occ_o(occ_o), .tok_cnt_o(tok_cnt_o)
    );

    typedef struct packed {
        logic       iv;
        logic       ordy;
        logic [7:0] id;
        logic [1:0] mw;
        logic       e_ir;
        logic       e_ov;
        logic [1:0] e_occ;
        logic [7:0] e_id;
        logic [1:0] e_mw;
        logic       e_wen;
    } vec_t;

    vec_t tbl [10];

    function automatic logic [15:0] tnode(input logic [7:0] id);
        return {8'h5A, id};
    endfunction
    function automatic logic [11:0] tgen(input logic [7:0] id);
        return {4'h3, id};
    endfunction
    function automatic logic [31:0] topr0(input logic [7:0] id);
        return {24'hC0DE00, id};
    endfunction
    function automatic logic [31:0] topr1(input logic [7:0] id);
        return {id, 24'h0BEEF1};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_tok(input string nm, input logic [7:0] id, input logic [1:0] mw);
        chk({nm, "_node"}, {16'h0, node_o}, {16'h0, tnode(id)});
        chk({nm, "_gen"}, {20'h0, gen_o}, {20'h0, tgen(id)});
        chk({nm, "_opr0"}, opr0_o, topr0(id));
        chk({nm, "_opr1"}, opr1_o, topr1(id));
        chk({nm, "_mw"}, {30'h0, mem_wen_o}, {30'h0, mw});
    endtask

    // Drive one cycle of inputs, advance one edge, and leave time 1 unit past the edge.
    task automatic step(input logic iv, input logic ordy, input logic [7:0] id,
                        input logic [1:0] mw, input logic eov);
        in_valid  = iv;
        out_ready = ordy;
        node_i    = tnode(id);
        gen_i     = tgen(id);
        opr0_i    = topr0(id);
        opr1_i    = topr1(id);
        mem_wen_i = mw;
`ifdef FTC_SKID_TOKCNT_EN
        if (prev_ov && ordy) exp_cnt = exp_cnt + 16'd1;
`endif
        prev_ov = eov;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_ov"}, {31'h0, out_valid}, 32'h0);
        chk({nm, "_ir"}, {31'h0, in_ready}, 32'h0);
        chk({nm, "_occ"}, {30'h0, occ_o}, 32'h0);
        chk({nm, "_wen"}, {31'h0, w_en_cex_o}, 32'h1);
        chk({nm, "_tok"}, {16'h0, tok_cnt_o}, 32'h0);
        chk({nm, "_node"}, {16'h0, node_o}, 32'h0);
        chk({nm, "_gen"}, {20'h0, gen_o}, 32'h0);
        chk({nm, "_opr0"}, opr0_o, 32'h0);
        chk({nm, "_opr1"}, opr1_o, 32'h0);
        chk({nm, "_mw"}, {30'h0, mem_wen_o}, 32'h0);
    endtask

    initial begin
        //              iv    or    id     mw     ir    ov    occ    eid    emw    wen
        tbl[0] = '{1'b1, 1'b1, 8'h01, 2'b10, 1'b1, 1'b1, 2'd1, 8'h01, 2'b10, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 8'h02, 2'b01, 1'b0, 1'b1, 2'd2, 8'h01, 2'b10, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 8'h03, 2'b11, 1'b0, 1'b1, 2'd2, 8'h01, 2'b10, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 8'hEE, 2'b10, 1'b1, 1'b1, 2'd1, 8'h02, 2'b01, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 8'h04, 2'b00, 1'b1, 1'b1, 2'd1, 8'h04, 2'b00, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 8'hEE, 2'b10, 1'b1, 1'b0, 2'd0, 8'h00, 2'b00, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 8'hEE, 2'b10, 1'b1, 1'b0, 2'd0, 8'h00, 2'b00, 1'b1};
        tbl[7] = '{1'b1, 1'b0, 8'h05, 2'b10, 1'b1, 1'b1, 2'd1, 8'h05, 2'b10, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 8'hEE, 2'b01, 1'b1, 1'b1, 2'd1, 8'h05, 2'b10, 1'b0};
        tbl[9] = '{1'b0, 1'b1, 8'hEE, 2'b01, 1'b1, 1'b0, 2'd0, 8'h00, 2'b00, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("por");
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, 1'b0, 8'hEE, 2'b00, 1'b0);
        chk("rel_ir", {31'h0, in_ready}, 32'h1);
        chk("rel_ov", {31'h0, out_valid}, 32'h0);

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].iv, tbl[i].ordy, tbl[i].id, tbl[i].mw, tbl[i].e_ov);
            chk($sformatf("v%0d_ir", i), {31'h0, in_ready}, {31'h0, tbl[i].e_ir});
            chk($sformatf("v%0d_ov", i), {31'h0, out_valid}, {31'h0, tbl[i].e_ov});
            chk($sformatf("v%0d_occ", i), {30'h0, occ_o}, {30'h0, tbl[i].e_occ});
            chk($sformatf("v%0d_wen", i), {31'h0, w_en_cex_o}, {31'h0, tbl[i].e_wen});
            chk($sformatf("v%0d_tok", i), {16'h0, tok_cnt_o}, {16'h0, exp_cnt});
            if (tbl[i].e_ov) chk_tok($sformatf("v%0d", i), tbl[i].e_id, tbl[i].e_mw);
        end

        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 8'h10 + 8'(i), 2'b01, 1'b1);
            chk($sformatf("b2b%0d_ov", i), {31'h0, out_valid}, 32'h1);
            chk($sformatf("b2b%0d_occ", i), {30'h0, occ_o}, 32'h1);
            chk($sformatf("b2b%0d_ir", i), {31'h0, in_ready}, 32'h1);
            chk_tok($sformatf("b2b%0d", i), 8'h10 + 8'(i), 2'b01);
        end
        step(1'b0, 1'b1, 8'hEE, 2'b00, 1'b0);
        chk("b2b_end_ov", {31'h0, out_valid}, 32'h0);
        chk("b2b_end_tok", {16'h0, tok_cnt_o}, {16'h0, exp_cnt});

        step(1'b1, 1'b0, 8'h30, 2'b10, 1'b1);
        step(1'b1, 1'b0, 8'h31, 2'b01, 1'b1);
        chk("full_occ", {30'h0, occ_o}, 32'h2);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        prev_ov = 1'b0;
        exp_cnt = '0;
        @(posedge clk);
        #1;
        chk_reset_outputs("hold_rst");
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, 1'b1, 8'hEE, 2'b00, 1'b0);
        chk("post_rst_ir", {31'h0, in_ready}, 32'h1);
        chk("post_rst_ov", {31'h0, out_valid}, 32'h0);
        step(1'b0, 1'b1, 8'hEE, 2'b00, 1'b0);
        chk("post_rst_ov2", {31'h0, out_valid}, 32'h0);
        chk("post_rst_occ", {30'h0, occ_o}, 32'h0);

`ifdef FTC_SKID_TOKCNT_EN
        for (int i = 0; i < 65537; i++) step(1'b1, 1'b1, 8'(i), 2'b00, 1'b1);
`else
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 8'(i), 2'b00, 1'b1);
`endif
        step(1'b0, 1'b1, 8'hEE, 2'b00, 1'b0);
        chk("cnt_final", {16'h0, tok_cnt_o}, {16'h0, exp_cnt});
        chk("cnt_ov", {31'h0, out_valid}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ftc_skid_stage.md
FTC_SKID_STAGE -- requirements
Module: ftc_skid_stage

Interface
REQ-001 The block SHALL have parameter NODE_W, default 16, meaning destination node field width.
REQ-002 The block SHALL have parameter GEN_W, default 12, meaning generation/colour field width.
REQ-003 The block SHALL have parameter OPR_W, default 32, meaning width of each operand.
REQ-004 The block SHALL have port clk, input, 1, clock; all registers update on the rising edge.
REQ-005 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1, upstream token present.
REQ-007 The block SHALL have port in_ready, output, 1, stage can accept a token this cycle.
REQ-008 The block SHALL have ports node_i, gen_i, opr0_i, opr1_i, input, NODE_W/GEN_W/OPR_W/OPR_W, incoming token fields.
REQ-009 The block SHALL have port mem_wen_i, input, 2, with encoding 00 none, 01 Data Mem, 10 Ins Mem, 11 Type Mem.
REQ-010 The block SHALL have port out_valid, output, 1, downstream token present.
REQ-011 The block SHALL have port out_ready, input, 1, downstream accepts this cycle.
REQ-012 The block SHALL have ports node_o, gen_o, opr0_o, opr1_o, mem_wen_o, output, same widths as inputs, head token fields.
REQ-013 The block SHALL have port w_en_cex_o, output, 1, active-low Ins Mem write enable to the CEX stage.
REQ-014 The block SHALL have port occ_o, output, 2, number of tokens held (0..2).
REQ-015 The block SHALL have port tok_cnt_o, output, 16, count of tokens delivered downstream.

Function
REQ-016 The block SHALL transfer input on in_valid&&in_ready and output on out_valid&&out_ready.
REQ-017 The block SHALL hold tokens in a head register driving the outputs plus one skid register, with states EMPTY (occ 0), ONE (occ 1), FULL (occ 2).
REQ-018 The block SHALL transition EMPTY->ONE on input; ONE->FULL on input without output; ONE->EMPTY on output without input; ONE->ONE on simultaneous input and output; FULL->ONE on output.
REQ-019 The block SHALL drive in_ready = (state != FULL) from a register, with no combinational path from out_ready.
REQ-020 The block SHALL present a token at the outputs one cycle after acceptance into EMPTY, and SHALL sustain one token per cycle when out_ready stays high.
REQ-021 The block SHALL keep all output fields stable while out_valid=1 and out_ready=0.
REQ-022 The block SHALL deliver tokens in strict arrival order; on FULL->ONE, the skid token SHALL move to the head register in the same edge.
REQ-023 The block SHALL drive out_valid = (state != EMPTY).
REQ-024 The block SHALL drive w_en_cex_o = 0 only when out_valid=1 and mem_wen_o=2'b10, and 1 otherwise.
REQ-025 The block SHALL ignore input fields when in_valid=0 and SHALL NOT alter stored data.
REQ-026 The block SHALL take no action on in_valid=1 while in_ready=0; holding the token is the upstream's responsibility.

Reset
REQ-027 The block SHALL, on rst=0 at any time including mid-transfer, clear state to EMPTY and discard held tokens.
REQ-028 The block SHALL, during reset, drive all data fields and mem_wen_o to 0, out_valid=0, in_ready=0, occ_o=0, w_en_cex_o=1 and tok_cnt_o=0.
REQ-029 The block SHALL drive in_ready=1 from the first rising clk edge after rst deasserts.

Configuration
REQ-030 The block SHALL use macro FTC_SKID_TOKCNT_EN to select the delivery counter.
REQ-031 With FTC_SKID_TOKCNT_EN defined, tok_cnt_o SHALL increment by 1 per output handshake and wrap from 16'hFFFF to 16'h0000.
REQ-032 Without FTC_SKID_TOKCNT_EN, tok_cnt_o SHALL be constant 0 and no counter register SHALL be built.

Verification
REQ-033 The bench SHALL check that 8 back-to-back tokens with out_ready=1 appear one cycle later, one per cycle, with occ_o=1 throughout.
REQ-034 The bench SHALL check that with out_ready=0, tokens A then B give occ_o=2 and in_ready=0, with A held stable; releasing out_ready yields A then B in order.
REQ-035 The bench SHALL check that simultaneous input and output in ONE keeps occ_o=1 and shows the new token on the next cycle.
REQ-036 The bench SHALL check that a held token with mem_wen=2'b10 gives w_en_cex_o=0, that mem_wen=2'b01 gives 1, and that an empty stage gives 1.
REQ-037 The bench SHALL check that asserting rst while FULL gives out_valid=0, occ_o=0 and zero fields immediately, and that no old token appears after release.
REQ-038 The bench SHALL check, with FTC_SKID_TOKCNT_EN, that 65537 deliveries give tok_cnt_o=1 (wrap), and without it that tok_cnt_o stays 0.
